// File: rtl/tone_pkg.sv
// Shared definitions for the tone front-end: address map, write window start,
// FSM state encodings and the packed command/debug records.
package tone_pkg;

    localparam logic [1:0] ADDR_INCR = 2'h0;
    localparam logic [1:0] ADDR_VOL  = 2'h1;
    localparam logic [1:0] ADDR_WAVE = 2'h2;
    localparam logic [1:0] ADDR_RATE = 2'h3;

    localparam int WINDOW_START = 16;

    typedef enum logic [1:0] {
        ASM_IDLE,
        ASM_GOT_ADDR,
        ASM_GOT_HI,
        ASM_PENDING
    } asm_state_t;

    typedef enum logic {
        ENV_IDLE,
        ENV_RUN
    } env_state_t;

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } tone_cmd_t;

    typedef struct packed {
        asm_state_t asm_state;
        env_state_t env_state;
        logic [1:0] env_ch;
        logic [7:0] presc;
    } tone_dbg_t;

endpackage

// File: rtl/tone_scheduler_if.sv
// Host byte bus into the tone scheduler.
// A byte transfers in any cycle where host_valid_in and host_ready_out are both high;
// a byte offered while host_ready_out is low is lost, never held or retried.
interface tone_scheduler_if;
    logic [7:0] host_data_in;
    logic       host_valid_in;
    logic       host_first_in;
    logic       host_ready_out;

    modport master (
        output host_data_in,
        output host_valid_in,
        output host_first_in,
        input  host_ready_out
    );

    modport slave (
        input  host_data_in,
        input  host_valid_in,
        input  host_first_in,
        output host_ready_out
    );
endinterface

// File: rtl/tone_scheduler_host_frame_assembler.sv
// Collects address/high/low host bytes into one pending 16-bit register command
// and holds it (with ready low) until the top consumes it.
module host_frame_assembler
    import tone_pkg::*;
(
    input  logic               clk_in,
    input  logic               reset_in,
    tone_scheduler_if.slave    host,
    input  logic               pend_done,
    output logic               pend_valid,
    output tone_cmd_t          pend_cmd,
    output asm_state_t         state_dbg
);

    asm_state_t state, state_next;
    logic       load_addr, load_hi, load_lo;
    logic [3:0] addr_q;
    logic [7:0] hi_q, lo_q;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state  <= ASM_IDLE;
            addr_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            state <= state_next;
            if (load_addr) addr_q <= host.host_data_in[3:0];
            if (load_hi)   hi_q   <= host.host_data_in;
            if (load_lo)   lo_q   <= host.host_data_in;
        end
    end

    // A first-flagged byte restarts any partial frame; PENDING ignores all bytes.
    always_comb begin
        state_next = state;
        load_addr  = 1'b0;
        load_hi    = 1'b0;
        load_lo    = 1'b0;
        if (state == ASM_PENDING) begin
            if (pend_done) state_next = ASM_IDLE;
        end else if (host.host_valid_in) begin
            if (host.host_first_in) begin
                load_addr  = 1'b1;
                state_next = ASM_GOT_ADDR;
            end else if (state == ASM_GOT_ADDR) begin
                load_hi    = 1'b1;
                state_next = ASM_GOT_HI;
            end else if (state == ASM_GOT_HI) begin
                load_lo    = 1'b1;
                state_next = ASM_PENDING;
            end
        end
    end

    assign host.host_ready_out = (state != ASM_PENDING);
    assign pend_valid          = (state == ASM_PENDING);
    assign pend_cmd.addr       = addr_q;
    assign pend_cmd.data       = {hi_q, lo_q};
    assign state_dbg           = state;

endmodule

// File: rtl/tone_scheduler.sv
// Tone datapath front-end: master count, host command issue, per-channel
// volume-decay envelope and the single-write-port arbiter.
module tone_scheduler
    import tone_pkg::*;
#(
    parameter int ENV_DIV = 64
)
(
    input  logic              clk_in,
    input  logic              reset_in,
    tone_scheduler_if.slave   host,
    output logic [9:0]        master_count_out,
    output logic [15:0]       data_out,
    output logic [3:0]        addr_out,
    output logic              data_valid_out,
    output tone_dbg_t         dbg_out
);

    localparam logic [7:0] PRESC_LAST = 8'(ENV_DIV - 1);

    logic       pend_valid, pend_done;
    tone_cmd_t  pend_cmd;
    asm_state_t asm_state;

    env_state_t env_state, env_state_next;
    logic [1:0] env_ch, env_ch_next;
    logic [7:0] presc;
    logic [7:0] rate   [4];
    logic [7:0] shadow [4];

    logic [9:0] count_next;
    logic       win_next, frame_end, tick;
    logic       pend_is_rate, host_issue, rate_apply;
    logic       env_issue, env_step;
    logic [7:0] cur_rate, cur_vol, dec_vol;

    host_frame_assembler u_asm (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .host      (host),
        .pend_done (pend_done),
        .pend_valid(pend_valid),
        .pend_cmd  (pend_cmd),
        .state_dbg (asm_state)
    );

    // Outputs are registered, so a write is launched when the *next* count is in the window.
    assign count_next   = master_count_out + 10'd1;
    assign win_next     = (count_next >= 10'(WINDOW_START));
    assign frame_end    = (master_count_out == 10'd1023);
    assign tick         = frame_end && (presc == PRESC_LAST);

    assign pend_is_rate = (pend_cmd.addr[3:2] == ADDR_RATE);
    assign host_issue   = pend_valid && !pend_is_rate && win_next;
    assign rate_apply   = pend_valid && pend_is_rate;
    assign pend_done    = host_issue || rate_apply;

    assign cur_rate     = rate[env_ch];
    assign cur_vol      = shadow[env_ch];
    assign dec_vol      = (cur_vol > cur_rate) ? (cur_vol - cur_rate) : 8'h00;
    assign env_issue    = (env_state == ENV_RUN) && (cur_rate != 8'h00) && win_next && !host_issue;
    assign env_step     = (env_state == ENV_RUN) && ((cur_rate == 8'h00) || env_issue);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            env_state <= ENV_IDLE;
            env_ch    <= 2'd0;
        end else begin
            env_state <= env_state_next;
            env_ch    <= env_ch_next;
        end
    end

    // A tick seen while a scan is running is simply lost.
    always_comb begin
        env_state_next = env_state;
        env_ch_next    = env_ch;
        case (env_state)
            ENV_IDLE: begin
                if (tick) begin
                    env_state_next = ENV_RUN;
                    env_ch_next    = 2'd0;
                end
            end
            ENV_RUN: begin
                if (env_step) begin
                    env_ch_next = env_ch + 2'd1;
                    if (env_ch == 2'd3) env_state_next = ENV_IDLE;
                end
            end
            default: env_state_next = ENV_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            master_count_out <= '0;
            presc            <= '0;
            data_out         <= '0;
            addr_out         <= '0;
            data_valid_out   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                rate[i]   <= '0;
                shadow[i] <= '0;
            end
        end else begin
            master_count_out <= count_next;
            if (frame_end) presc <= tick ? 8'd0 : presc + 8'd1;
            data_valid_out <= host_issue || env_issue;
            if (host_issue) begin
                addr_out <= pend_cmd.addr;
                data_out <= pend_cmd.data;
                if (pend_cmd.addr[3:2] == ADDR_VOL) shadow[pend_cmd.addr[1:0]] <= pend_cmd.data[7:0];
            end else if (env_issue) begin
                addr_out       <= {ADDR_VOL, env_ch};
                data_out       <= {8'h00, dec_vol};
                shadow[env_ch] <= dec_vol;
            end
            if (rate_apply) rate[pend_cmd.addr[1:0]] <= pend_cmd.data[7:0];
        end
    end

    assign dbg_out.asm_state = asm_state;
    assign dbg_out.env_state = env_state;
    assign dbg_out.env_ch    = env_ch;
    assign dbg_out.presc     = presc;

endmodule

// File: tb/tb_tone_scheduler.sv
// Bench for tone_scheduler: cycle-level behavioural model compared every cycle,
// plus directed scenarios with hand-computed write lists.
module tb_tone_scheduler;
  import tone_pkg::*;

  localparam int ENV_DIV = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  count;
  logic [15:0] data;
  logic [3:0]  addr;
  logic        valid;
  tone_dbg_t   dbg;

  tone_scheduler_if hif ();

  tone_scheduler #(.ENV_DIV(ENV_DIV)) dut (
    .clk_in          (clk),
    .reset_in        (rst),
    .host            (hif),
    .master_count_out(count),
    .data_out        (data),
    .addr_out        (addr),
    .data_valid_out  (valid),
    .dbg_out         (dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  // observed writes {count, addr, data} and expected writes for directed cases
  logic [29:0] obs_q[$];
  logic [29:0] exp_q[$];

  // ---------------- behavioural model ----------------
  int m_count, m_presc, m_nb, m_addr, m_hi, m_pend_addr, m_pend_data, m_ch;
  bit m_pend, m_run;
  int m_rate[4];
  int m_shadow[4];
  logic        e_valid, e_ready;
  logic [3:0]  e_addr;
  logic [15:0] e_data;

  always @(posedge clk) begin : model
    int  c_next, nv;
    bit  win, pend_rate, h_iss, e_iss, step, old_pend, old_run;
    if (rst) begin
      m_count = 0; m_presc = 0; m_nb = 0; m_addr = 0; m_hi = 0;
      m_pend = 0; m_pend_addr = 0; m_pend_data = 0; m_run = 0; m_ch = 0;
      for (int i = 0; i < 4; i++) begin m_rate[i] = 0; m_shadow[i] = 0; end
      e_valid = 0; e_ready = 1; e_addr = 0; e_data = 0;
    end else begin
      c_next    = (m_count + 1) % 1024;
      win       = (c_next >= 16);
      old_pend  = m_pend;
      old_run   = m_run;
      pend_rate = m_pend && (m_pend_addr >= 12);
      h_iss     = m_pend && !pend_rate && win;
      e_iss     = !h_iss && m_run && (m_rate[m_ch] != 0) && win;
      step      = m_run && ((m_rate[m_ch] == 0) || e_iss);
      e_valid   = h_iss || e_iss;
      if (h_iss) begin
        e_addr = 4'(m_pend_addr);
        e_data = 16'(m_pend_data);
        if (m_pend_addr / 4 == 1) m_shadow[m_pend_addr % 4] = m_pend_data % 256;
        m_pend = 0;
      end else if (e_iss) begin
        nv = m_shadow[m_ch] - m_rate[m_ch];
        if (nv < 0) nv = 0;
        m_shadow[m_ch] = nv;
        e_addr = 4'(4 + m_ch);
        e_data = 16'(nv);
      end
      if (step) begin
        if (m_ch == 3) m_run = 0;
        m_ch = (m_ch + 1) % 4;
      end
      if (pend_rate) begin
        m_rate[m_pend_addr % 4] = m_pend_data % 256;
        m_pend = 0;
      end
      if (hif.host_valid_in && !old_pend) begin
        if (hif.host_first_in) begin
          m_addr = int'(hif.host_data_in[3:0]); m_nb = 1;
        end else if (m_nb == 1) begin
          m_hi = int'(hif.host_data_in); m_nb = 2;
        end else if (m_nb == 2) begin
          m_pend_addr = m_addr; m_pend_data = m_hi * 256 + int'(hif.host_data_in);
          m_pend = 1; m_nb = 0;
        end
      end
      if (m_count == 1023) begin
        if (m_presc == ENV_DIV - 1) begin
          m_presc = 0;
          if (!old_run) begin m_run = 1; m_ch = 0; end
        end else begin
          m_presc = m_presc + 1;
        end
      end
      m_count = c_next;
      e_ready = !m_pend;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if ({count, valid, hif.host_ready_out, addr, data} !== {10'(m_count), e_valid, e_ready, e_addr, e_data}) begin
        errors++;
        if (errors <= 20)
          $display("FAIL cycle_cmp t=%0t got/want count=%0d/%0d valid=%0b/%0b ready=%0b/%0b addr=%h/%h data=%h/%h",
                   $time, count, m_count, valid, e_valid, hif.host_ready_out, e_ready, addr, e_addr, data, e_data);
      end
      if (valid === 1'b1) begin
        checks++;
        if (count < 10'd16) begin
          errors++;
          $display("FAIL window got count=%0d want >=16", count);
        end
        obs_q.push_back({count, addr, data});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] b, input logic f);
    hif.host_data_in  = b;
    hif.host_valid_in = 1'b1;
    hif.host_first_in = f;
    @(negedge clk);
    hif.host_valid_in = 1'b0;
    hif.host_first_in = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] a, input logic [7:0] hi, input logic [7:0] lo);
    send(a, 1'b1);
    send(hi, 1'b0);
    send(lo, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hif.host_valid_in = 1'b0;
    hif.host_first_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_count(input int c);
    int n;
    n = 0;
    while (m_count != c && n < 2100) begin
      @(negedge clk);
      n++;
    end
    if (m_count != c) begin
      checks++; errors++;
      $display("FAIL wait_count got %0d want %0d", m_count, c);
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic check_writes(input string name);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s write count got %0d want %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s write %0d got count=%0d addr=%h data=%h want count=%0d addr=%h data=%h",
                 name, i, obs_q[i][29:20], obs_q[i][19:16], obs_q[i][15:0],
                 exp_q[i][29:20], exp_q[i][19:16], exp_q[i][15:0]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    hif.host_data_in  = 8'h00;
    hif.host_valid_in = 1'b0;
    hif.host_first_in = 1'b0;
    repeat (2) @(negedge clk);
    started = 1'b1;

    // reset state
    check_lit("reset_count", 32'(count), 32'd0);
    check_lit("reset_outs", {27'd0, valid, hif.host_ready_out, dbg.asm_state, dbg.env_state},
              {27'd0, 1'b0, 1'b1, ASM_IDLE, ENV_IDLE});
    check_lit("reset_bus", {12'd0, addr, data}, 32'd0);

    // free run: 1100 clocks, no writes
    rst = 1'b0;
    obs_q.delete();
    repeat (1099) @(negedge clk);
    check_lit("count_wrap", 32'(count), 32'd75);
    check_writes("idle_run");

    // single command before the window opens
    do_reset();
    wait_count(1);
    send_cmd(8'h01, 8'h12, 8'h34);
    wait_count(10);
    check_lit("ready_low_pending", 32'(hif.host_ready_out), 32'd0);
    wait_count(16);
    check_lit("ready_at_write", {30'd0, valid, hif.host_ready_out}, 32'd3);
    wait_count(40);
    exp_q.push_back({10'd16, 4'h1, 16'h1234});
    check_writes("first_cmd");

    // partial frame restarted by a new first byte
    wait_count(50);
    send(8'h05, 1'b1);
    send(8'hAA, 1'b0);
    send_cmd(8'h06, 8'h00, 8'h80);
    wait_count(80);
    exp_q.push_back({10'd56, 4'h6, 16'h0080});
    check_writes("partial_frame");

    // bytes while ready is low, and a stray non-first byte in IDLE
    do_reset();
    send_cmd(8'h02, 8'hAB, 8'hCD);
    wait_count(5);
    send_cmd(8'h07, 8'h11, 8'h22);
    wait_count(30);
    send(8'h33, 1'b0);
    wait_count(60);
    exp_q.push_back({10'd16, 4'h2, 16'hABCD});
    check_writes("dropped_bytes");

    // linear decay on ch2: 0x20 with rate 0x0C
    do_reset();
    send_cmd(8'h06, 8'h00, 8'h20);
    wait_count(20);
    send_cmd(8'h0E, 8'h00, 8'h0C);
    wait_count(40);
    exp_q.push_back({10'd16, 4'h6, 16'h0020});
    check_writes("decay_setup");
    repeat (8 * 1024 + 100 - 40) @(negedge clk);
    exp_q.push_back({10'd16, 4'h6, 16'h0014});
    exp_q.push_back({10'd16, 4'h6, 16'h0008});
    exp_q.push_back({10'd16, 4'h6, 16'h0000});
    exp_q.push_back({10'd16, 4'h6, 16'h0000});
    check_writes("decay");

    // host command finishing at count 1023 of a tick frame beats the envelope
    do_reset();
    send_cmd(8'h0C, 8'h00, 8'h01);
    wait_count(1021);
    repeat (1024) @(negedge clk);
    send_cmd(8'h04, 8'h00, 8'h10);
    wait_count(100);
    exp_q.push_back({10'd16, 4'h4, 16'h0010});
    exp_q.push_back({10'd17, 4'h4, 16'h000F});
    check_writes("host_priority");

    // reset in the middle of a scan clears everything
    do_reset();
    for (int ch = 0; ch < 4; ch++) begin
      send_cmd(8'(8'h0C + ch), 8'h00, 8'h02);
      @(negedge clk);
    end
    repeat (2048 + 17 - m_count) @(negedge clk);
    check_lit("midscan_write", {27'd0, valid, addr}, {27'd0, 1'b1, 4'h5});
    do_reset();
    repeat (3 * 1024) @(negedge clk);
    check_writes("after_reset");

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 9000; i++) begin
      hif.host_valid_in = ($urandom_range(0, 2) != 0);
      hif.host_first_in = ($urandom_range(0, 2) == 0);
      hif.host_data_in  = 8'($urandom_range(0, 255));
      if (i == 6000) rst = 1'b1;
      if (i == 6003) rst = 1'b0;
      @(negedge clk);
    end
    hif.host_valid_in = 1'b0;
    repeat (50) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
